// File: rtl/hog_band_collector_pkg.sv
// Shared sizes and read-FSM encoding for the HOG band collector.
package hog_pkg;
    localparam int PIX_W  = 12;
    localparam int TILES  = 53;
    localparam int BANDS  = 160;
    localparam int TILE_W = 12 * PIX_W;
    localparam int SEG_W  = 6;
    localparam int BAND_W = 8;

    localparam logic [SEG_W-1:0]  LAST_SEG  = SEG_W'(TILES - 1);
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(BANDS - 1);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_STREAM,
        RD_DONE
    } rd_state_t;
endpackage

// File: rtl/hog_band_collector_bank.sv
// One band buffer: 3 rows x TILES segments; writes a whole tile (3 row words)
// per cycle, reads one segment per cycle into a registered output.
module hog_band_bank
    import hog_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SEG_W-1:0]    wr_seg,
    input  logic [3*TILE_W-1:0] wr_words,
    input  logic                rd_en,
    input  logic [1:0]          rd_row,
    input  logic [SEG_W-1:0]    rd_seg,
    output logic [TILE_W-1:0]   rd_data
);
    logic [2:0][TILE_W-1:0] row_q;

    for (genvar r = 0; r < 3; r++) begin : g_row
        logic [TILE_W-1:0] mem [TILES];

        always_ff @(posedge clk) begin
            if (wr_en)
                mem[wr_seg] <= wr_words[TILE_W*(r+1)-1 -: TILE_W];
        end

        assign row_q[r] = mem[rd_seg];
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= row_q[rd_row];
    end
endmodule

// File: rtl/hog_band_collector.sv
// Reassembles 3x12 HOG magnitude tiles into ping-pong band buffers and replays
// each band row by row as 12-pixel segments over valid/ready.
module hog_band_collector
    import hog_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [9*PIX_W-1:0] block_in_0,
    input  logic [9*PIX_W-1:0] block_in_1,
    input  logic [9*PIX_W-1:0] block_in_2,
    input  logic [9*PIX_W-1:0] block_in_3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TILE_W-1:0]  out_data,
    output logic [8:0]         out_row,
    output logic [5:0]         out_seg,
    output logic               overflow,
    output logic               frame_done
);
    logic [SEG_W-1:0]          wr_tile;
    logic [BAND_W-1:0]         wr_band;
    logic                      wr_bank, drop;
    logic [1:0]                full;
    logic [1:0][BAND_W-1:0]    tag;
    logic                      wr_first, wr_last, drop_now, wr_en, wr_done;
    logic [1:0]                set_vec, free_vec, avail;
    logic [3*TILE_W-1:0]       row_words;

    rd_state_t                 state, state_n;
    logic [1:0]                rd_row, row_n;
    logic [SEG_W-1:0]          rd_seg, seg_n;
    logic [BAND_W-1:0]         rd_band, band_n;
    logic                      rd_bank, bank_n, rd_ld, ld_bank, last_xfer;
    logic [1:0][TILE_W-1:0]    bank_q;

    // Each block row is three contiguous elements with the highest column on top.
    for (genvar r = 0; r < 3; r++) begin : g_rowword
        localparam int HI = PIX_W*(9-3*r) - 1;
        assign row_words[TILE_W*(r+1)-1 -: TILE_W] = {block_in_0[HI -: 3*PIX_W],
                                                      block_in_1[HI -: 3*PIX_W],
                                                      block_in_2[HI -: 3*PIX_W],
                                                      block_in_3[HI -: 3*PIX_W]};
    end

    assign last_xfer = (state == RD_STREAM) && out_ready &&
                       (rd_row == 2'd2) && (rd_seg == LAST_SEG);
    assign free_vec  = {last_xfer && rd_bank, last_xfer && !rd_bank};

    // A bank freed on this very edge counts as empty for the drop decision.
    assign wr_first = in_valid && (wr_tile == '0);
    assign wr_last  = in_valid && (wr_tile == LAST_SEG);
    assign drop_now = wr_first ? (full[wr_bank] && !free_vec[wr_bank]) : drop;
    assign wr_en    = in_valid && !drop_now;
    assign wr_done  = wr_last && !drop_now;
    assign set_vec  = {wr_done && wr_bank, wr_done && !wr_bank};
    assign avail    = full | set_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_tile  <= '0;
            wr_band  <= '0;
            wr_bank  <= 1'b0;
            drop     <= 1'b0;
            overflow <= 1'b0;
            full     <= '0;
            tag      <= '0;
        end else begin
            if (in_valid) begin
                drop <= drop_now;
                if (wr_first && drop_now)
                    overflow <= 1'b1;
                if (wr_last) begin
                    wr_tile <= '0;
                    wr_band <= (wr_band == LAST_BAND) ? '0 : wr_band + 8'd1;
                end else begin
                    wr_tile <= wr_tile + 6'd1;
                end
                if (wr_done) begin
                    wr_bank      <= ~wr_bank;
                    tag[wr_bank] <= wr_band;
                end
            end
            full <= (full & ~free_vec) | set_vec;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        hog_band_bank u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en && (wr_bank == 1'(b))),
            .wr_seg   (wr_tile),
            .wr_words (row_words),
            .rd_en    (rd_ld && (ld_bank == 1'(b))),
            .rd_row   (row_n),
            .rd_seg   (seg_n),
            .rd_data  (bank_q[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RD_IDLE;
            rd_row  <= '0;
            rd_seg  <= '0;
            rd_band <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_n;
            rd_row  <= row_n;
            rd_seg  <= seg_n;
            rd_band <= band_n;
            rd_bank <= bank_n;
        end
    end

    // rd_ld fetches the segment that will be on the output next cycle; a band
    // completing on the last-beat edge is picked up without a bubble.
    always_comb begin
        state_n = state;
        row_n   = rd_row;
        seg_n   = rd_seg;
        band_n  = rd_band;
        bank_n  = rd_bank;
        rd_ld   = 1'b0;
        ld_bank = rd_bank;
        case (state)
            RD_IDLE: begin
                if (avail[rd_bank]) begin
                    state_n = RD_STREAM;
                    row_n   = '0;
                    seg_n   = '0;
                    band_n  = full[rd_bank] ? tag[rd_bank] : wr_band;
                    rd_ld   = 1'b1;
                end
            end
            RD_STREAM: begin
                if (out_ready) begin
                    if (last_xfer) begin
                        bank_n = ~rd_bank;
                        if (rd_band == LAST_BAND) begin
                            state_n = RD_DONE;
                        end else if (avail[~rd_bank]) begin
                            row_n   = '0;
                            seg_n   = '0;
                            band_n  = full[~rd_bank] ? tag[~rd_bank] : wr_band;
                            rd_ld   = 1'b1;
                            ld_bank = ~rd_bank;
                        end else begin
                            state_n = RD_IDLE;
                        end
                    end else begin
                        rd_ld = 1'b1;
                        if (rd_seg == LAST_SEG) begin
                            seg_n = '0;
                            row_n = rd_row + 2'd1;
                        end else begin
                            seg_n = rd_seg + 6'd1;
                        end
                    end
                end
            end
            RD_DONE: begin
                state_n = RD_IDLE;
                band_n  = '0;
            end
            default: state_n = RD_IDLE;
        endcase
    end

    assign out_valid  = (state == RD_STREAM);
    assign frame_done = (state == RD_DONE);
    assign out_data   = bank_q[rd_bank];
    assign out_seg    = rd_seg;
    assign out_row    = {1'b0, rd_band} * 9'd3 + {7'b0, rd_row};
endmodule

// File: tb/tb_hog_band_collector.sv
// Scoreboard bench: a band-level model predicts every output segment; a
// negedge monitor pops and compares on each accepted beat.
module tb_hog_band_collector;
    import hog_pkg::*;

    typedef struct {
        logic [8:0]        row;
        logic [5:0]        seg;
        logic [TILE_W-1:0] data;
        bit                last_band;
        bit                last_frame;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [9*PIX_W-1:0] blk [4];
    logic               out_valid, overflow, frame_done;
    logic [TILE_W-1:0]  out_data;
    logic [8:0]         out_row;
    logic [5:0]         out_seg;

    int    n_cmp = 0, n_bad = 0;
    int    rdy_mode = 0;
    beat_t sb[$];
    int    held_full = 0, m_tile = 0, m_band = 0;
    bit    m_drop = 0;
    logic [TILE_W-1:0] tile_rows [TILES][3];
    beat_t nb, got;
    bit    stall_v = 0, fd_exp = 0;
    logic [TILE_W-1:0] h_data;
    logic [8:0]  h_row;
    logic [5:0]  h_seg;

    hog_band_collector dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .block_in_0 (blk[0]),
        .block_in_1 (blk[1]),
        .block_in_2 (blk[2]),
        .block_in_3 (blk[3]),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_seg    (out_seg),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [TILE_W-1:0] act, input logic [TILE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pixel at image row r of the tile, column c counted from the highest column.
    function automatic logic [PIX_W-1:0] pix_of(int r, int c);
        int e;
        e = 8 - 3*r - (c % 3);
        return blk[c/3][PIX_W*(e+1)-1 -: PIX_W];
    endfunction

    // Reference model: band bookkeeping at the level of whole bands and bank counts.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            held_full = 0;
            m_tile    = 0;
            m_band    = 0;
            m_drop    = 0;
        end else if (in_valid) begin
            if (m_tile == 0)
                m_drop = (held_full == 2);
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 12; c++)
                    tile_rows[m_tile][r][PIX_W*(12-c)-1 -: PIX_W] = pix_of(r, c);
            if (m_tile == TILES-1) begin
                if (!m_drop) begin
                    held_full++;
                    for (int r = 0; r < 3; r++)
                        for (int s = 0; s < TILES; s++) begin
                            nb.row        = 9'(m_band*3 + r);
                            nb.seg        = 6'(s);
                            nb.data       = tile_rows[s][r];
                            nb.last_band  = (r == 2) && (s == TILES-1);
                            nb.last_frame = nb.last_band && (m_band == BANDS-1);
                            sb.push_back(nb);
                        end
                end
                m_band = (m_band == BANDS-1) ? 0 : m_band + 1;
                m_tile = 0;
            end else begin
                m_tile++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_v = 0;
            fd_exp  = 0;
        end else begin
            if (fd_exp || frame_done === 1'b1) begin
                n_cmp++;
                if (frame_done !== fd_exp) begin
                    n_bad++;
                    $display("FAIL frame_done: got %0b expected %0b", frame_done, fd_exp);
                end
            end
            fd_exp = 0;
            if (stall_v) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== h_data || out_row !== h_row || out_seg !== h_seg) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%0b row=%0d seg=%0d data=%0h expected v=1 row=%0d seg=%0d data=%0h",
                             out_valid, out_row, out_seg, out_data, h_row, h_seg, h_data);
                end
            end
            stall_v = 0;
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL extra_beat: got row=%0d seg=%0d expected no beat", out_row, out_seg);
                end else begin
                    got = sb.pop_front();
                    if (out_data !== got.data || out_row !== got.row || out_seg !== got.seg) begin
                        n_bad++;
                        $display("FAIL beat: got row=%0d seg=%0d data=%0h expected row=%0d seg=%0d data=%0h",
                                 out_row, out_seg, out_data, got.row, got.seg, got.data);
                    end
                    if (got.last_band) held_full--;
                    if (got.last_frame) fd_exp = 1;
                end
            end else if (out_valid === 1'b1) begin
                stall_v = 1;
                h_data  = out_data;
                h_row   = out_row;
                h_seg   = out_seg;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic send_band(input int n, input bit pat, input bit chk_lat);
        logic [PIX_W-1:0] p;
        for (int t = 0; t < n; t++) begin
            in_valid = 1'b1;
            for (int b = 0; b < 4; b++)
                for (int e = 0; e < 9; e++) begin
                    p = pat ? {6'(t), 2'(b), 4'(e)} : PIX_W'($urandom);
                    blk[b][PIX_W*(e+1)-1 -: PIX_W] = p;
                end
            if (chk_lat && t == n-1)
                chk("lat_pre", out_valid, 0);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && out_valid === 1'b0) begin
                ok = 1;
                break;
            end
            step();
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d beats pending expected 0 within %0d cycles", nm, sb.size(), budget);
        end
    endtask

    initial begin
        bit found;
        for (int b = 0; b < 4; b++) blk[b] = '0;
        step();
        do_reset(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        chk("rst_seg", out_seg, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_fdone", frame_done, 0);

        // single patterned band, ready held high
        send_band(TILES, 1, 1);
        chk("lat_valid", out_valid, 1);
        chk("first_row", out_row, 0);
        chk("first_msb", out_data[TILE_W-1 -: PIX_W], 12'h008);
        chk("first_lsb", out_data[PIX_W-1:0], 12'h036);
        wait_drain("drain_t1", 400);
        chk("ovf_t1", overflow, 0);

        // same band with ready toggling
        rdy_mode = 1;
        send_band(TILES, 1, 0);
        wait_drain("drain_t2", 700);
        rdy_mode = 0;
        idle(2);

        // two bands spaced 106 idle cycles apart
        do_reset(2);
        send_band(TILES, 0, 0);
        idle(106);
        send_band(TILES, 0, 0);
        wait_drain("drain_t3", 600);
        chk("ovf_t3", overflow, 0);

        // three bands while stalled: third one dropped
        rdy_mode = 2;
        do_reset(2);
        repeat (3) send_band(TILES, 0, 0);
        idle(10);
        chk("ovf_t4", overflow, 1);
        rdy_mode = 0;
        wait_drain("drain_t4a", 800);
        send_band(TILES, 0, 0);
        wait_drain("drain_t4b", 400);
        chk("ovf_t4_sticky", overflow, 1);

        // tile 0 of band 2 coincides with the last beat of band 0
        do_reset(2);
        send_band(TILES, 0, 0);
        send_band(TILES, 0, 0);
        found = 0;
        for (int i = 0; i < 400; i++) begin
            if (out_valid === 1'b1 && out_row == 9'd2 && out_seg == 6'd52) begin
                found = 1;
                break;
            end
            step();
        end
        chk("t5_sync", found, 1);
        send_band(TILES, 0, 0);
        wait_drain("drain_t5", 800);
        chk("ovf_t5", overflow, 0);

        // reset mid-stream, partial band, then a fresh band
        do_reset(2);
        send_band(TILES, 0, 0);
        idle(20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", out_valid, 0);
        chk("t6_fdone", frame_done, 0);
        send_band(20, 0, 0);
        do_reset(1);
        send_band(TILES, 0, 0);
        chk("t6_row0", out_row, 0);
        wait_drain("drain_t6", 400);

        // full frame with lossless spacing, then one band of the next frame
        do_reset(2);
        for (int k = 0; k < BANDS; k++) begin
            send_band(TILES, 0, 0);
            idle(106);
        end
        send_band(TILES, 0, 0);
        wait_drain("drain_t7", 600);
        chk("ovf_t7", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
